// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..MaxDataBits data bits, optional parity, 1/2 stop bits.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
    parameter int Oversample  = 16,
    parameter int MaxDataBits = 9
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   en,
    input  logic                   in,
    input  logic [3:0]             dataBits,
    input  logic [1:0]             parityMode,
    input  logic                   twoStop,
    output logic [MaxDataBits-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   frameErr,
    output logic                   parityErr,
    output logic                   overrun,
    output logic                   breakDet
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge
    // START  | validating the start bit at its mid point
    // DATA   | shifting in data bits, LSB first
    // PARITY | sampling the parity bit
    // STOP1  | first stop bit; break or frame completion decided here
    // STOP2  | second stop bit
    // BREAK  | line held low, waiting for it to return high
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} stateT;

    localparam int CW = $clog2(Oversample);
    localparam logic [CW-1:0] CntTop = CW'(Oversample - 1);
    localparam logic [CW-1:0] CntMid = CW'(Oversample / 2 - 1);
    localparam logic [3:0]    MaxBits = 4'(MaxDataBits);

    stateT state, nextState;
    logic sync1, rxs, rxsPrev;
    logic [CW-1:0] cnt;
    logic [3:0] bitCnt, bitsL, bitsClamp;
    logic [MaxDataBits-1:0] shiftReg;
    logic twoStopL, anyHigh, frameErrAcc;
    logic midTick, endTick, startFrame, complete, breakNow, ferrNow, parEnL, parErrNow;

    assign midTick    = en && (cnt == CntMid);
    assign endTick    = en && (cnt == '0);
    assign startFrame = (state == IDLE) && (nextState == START);
    assign ferrNow    = frameErrAcc | ~rxs;

    always_comb begin
        if (dataBits < 4'd5)
            bitsClamp = 4'd5;
        else if (dataBits > MaxBits)
            bitsClamp = MaxBits;
        else
            bitsClamp = dataBits;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rxsPrev <= 1'b1;
        end else begin
            sync1   <= in;
            rxs     <= sync1;
            rxsPrev <= rxs;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parOddL, xorAcc, parErrAcc;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            parEnL    <= 1'b0;
            parOddL   <= 1'b0;
            xorAcc    <= 1'b0;
            parErrAcc <= 1'b0;
        end else if (startFrame) begin
            parEnL    <= (parityMode == 2'd1) || (parityMode == 2'd2);
            parOddL   <= (parityMode == 2'd2);
            xorAcc    <= 1'b0;
            parErrAcc <= 1'b0;
        end else if (state == DATA && midTick) begin
            xorAcc <= xorAcc ^ rxs;
        end else if (state == PARITY && midTick) begin
            // even: error when overall XOR is 1; odd: error when it is 0
            parErrAcc <= xorAcc ^ rxs ^ parOddL;
        end
    end

    assign parErrNow = parErrAcc;
`else
    logic unusedParity;
    assign unusedParity = ^parityMode;
    assign parEnL       = 1'b0;
    assign parErrNow    = 1'b0;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        complete  = 1'b0;
        breakNow  = 1'b0;
        case (state)
            IDLE:   if (rxsPrev && !rxs) nextState = START;
            START:  if (midTick && rxs) nextState = IDLE;
                    else if (endTick) nextState = DATA;
            DATA:   if (endTick && bitCnt == bitsL) nextState = parEnL ? PARITY : STOP1;
            PARITY: if (endTick) nextState = STOP1;
            STOP1: begin
                if (midTick) begin
                    if (!rxs && !anyHigh) begin
                        breakNow  = 1'b1;
                        nextState = BREAK;
                    end else if (!twoStopL) begin
                        complete  = 1'b1;
                        nextState = IDLE;
                    end
                end else if (endTick && twoStopL) begin
                    nextState = STOP2;
                end
            end
            STOP2: if (midTick) begin
                complete  = 1'b1;
                nextState = IDLE;
            end
            BREAK:  if (midTick && rxs) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt         <= CntTop;
            bitCnt      <= '0;
            bitsL       <= 4'd5;
            shiftReg    <= '0;
            twoStopL    <= 1'b0;
            anyHigh     <= 1'b0;
            frameErrAcc <= 1'b0;
        end else begin
            if (state != nextState)
                cnt <= CntTop;
            else if (en)
                cnt <= (cnt == '0) ? CntTop : cnt - 1'b1;

            if (startFrame) begin
                bitsL       <= bitsClamp;
                twoStopL    <= twoStop;
                shiftReg    <= '0;
                bitCnt      <= '0;
                anyHigh     <= 1'b0;
                frameErrAcc <= 1'b0;
            end else if (midTick) begin
                case (state)
                    DATA: begin
                        shiftReg <= shiftReg | ({{(MaxDataBits-1){1'b0}}, rxs} << bitCnt);
                        bitCnt   <= bitCnt + 1'b1;
                        anyHigh  <= anyHigh | rxs;
                    end
                    PARITY:  anyHigh <= anyHigh | rxs;
                    STOP1:   frameErrAcc <= ~rxs;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            data      <= '0;
            valid     <= 1'b0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            overrun   <= 1'b0;
            breakDet  <= 1'b0;
        end else begin
            overrun  <= 1'b0;
            breakDet <= breakNow;
            if (complete) begin
                if (!valid || ready) begin
                    data      <= shiftReg;
                    frameErr  <= ferrNow;
                    parityErr <= parErrNow;
                    valid     <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
